// File: rtl/optical_slot_requester.sv
// Requester side of the optical 8x8 grant arbiter: pending set, request strobe, guard + slot timing.
// Optional grant checking is enabled by defining OPTICAL_SLOT_GRANT_CHECK_EN.
module optical_slot_requester #(
  parameter int P_CHANNEL_NUM = 8,
  parameter int P_GUARD_LEN   = 4,
  parameter int P_SLOT_LEN    = 16,
  parameter int P_WAIT_MAX    = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [P_CHANNEL_NUM-1:0] i_ch_req,
  output logic [P_CHANNEL_NUM-1:0] o_pending,
  output logic [P_CHANNEL_NUM-1:0] o_arb_req,
  output logic [P_CHANNEL_NUM-1:0] o_arb_first_priority,
  output logic                     o_arb_req_valid,
  input  logic [P_CHANNEL_NUM-1:0] i_arb_grant,
  input  logic                     i_arb_grant_valid,
  output logic [P_CHANNEL_NUM-1:0] o_slot_grant,
  output logic                     o_slot_valid,
  output logic [P_CHANNEL_NUM-1:0] o_slot_done,
  output logic                     o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GUARD,
    S_SLOT,
    S_DONE
  } state_t;

  localparam int MAX_GS  = (P_GUARD_LEN > P_SLOT_LEN) ? P_GUARD_LEN : P_SLOT_LEN;
  localparam int MAX_ALL = (MAX_GS > P_WAIT_MAX) ? MAX_GS : P_WAIT_MAX;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(P_GUARD_LEN - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(P_SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(P_WAIT_MAX - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         wait_cnt;
  logic [CNT_W-1:0]         phase_cnt;
  logic                     sampling;
  logic                     grant_nz;
  logic                     grant_bad;
  logic                     grant_take;
  logic                     grant_drop;
  logic [P_CHANNEL_NUM-1:0] done_mask;

  assign sampling = (state == S_REQ) || (state == S_WAIT);
  assign grant_nz = |i_arb_grant;

`ifdef OPTICAL_SLOT_GRANT_CHECK_EN
  assign grant_bad = grant_nz && (!$onehot(i_arb_grant) || (|(i_arb_grant & ~o_arb_req)));
`else
  assign grant_bad = 1'b0;
`endif

  assign grant_take = sampling && i_arb_grant_valid && grant_nz && !grant_bad;
  assign grant_drop = sampling && i_arb_grant_valid && (!grant_nz || grant_bad);
  assign done_mask  = (state == S_DONE) ? o_slot_grant : '0;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|o_pending) state_nxt = S_REQ;
      S_REQ,
      S_WAIT: begin
        if (grant_take)                 state_nxt = S_GUARD;
        else if (grant_drop)            state_nxt = S_IDLE;
        else if (wait_cnt == WAIT_LAST) state_nxt = S_IDLE;
        else                            state_nxt = S_WAIT;
      end
      S_GUARD: if (phase_cnt == GUARD_LAST) state_nxt = S_SLOT;
      S_SLOT:  if (phase_cnt == SLOT_LAST)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_arb_req_valid = (state == S_REQ);
    o_slot_valid    = (state == S_SLOT);
    o_slot_done     = done_mask;
`ifdef OPTICAL_SLOT_GRANT_CHECK_EN
    o_err           = sampling && i_arb_grant_valid && grant_bad;
`else
    o_err           = 1'b0;
`endif
  end

  // Wait count spans REQ and WAIT so the strobe cycle counts as the first wait cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      if (!sampling) wait_cnt <= '0;
      else           wait_cnt <= wait_cnt + 1'b1;

      if (state_nxt != state)                          phase_cnt <= '0;
      else if ((state == S_GUARD) || (state == S_SLOT)) phase_cnt <= phase_cnt + 1'b1;
    end
  end

  // A request arriving in the DONE cycle re-sets the bit being cleared.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending            <= '0;
      o_arb_req            <= '0;
      o_arb_first_priority <= P_CHANNEL_NUM'(1);
      o_slot_grant         <= '0;
    end else begin
      o_pending <= (o_pending & ~done_mask) | i_ch_req;

      if ((state == S_IDLE) && (|o_pending)) o_arb_req <= o_pending;

      if (grant_take)             o_slot_grant <= i_arb_grant;
      else if (state == S_DONE)   o_slot_grant <= '0;

      if (state == S_DONE)
        o_arb_first_priority <= {o_slot_grant[P_CHANNEL_NUM-2:0], o_slot_grant[P_CHANNEL_NUM-1]};
    end
  end

endmodule

// File: tb/tb_optical_slot_requester.sv
// Directed self-checking bench for optical_slot_requester with a behavioural fixed-priority arbiter.
module tb_optical_slot_requester;

  localparam int N = 8;
  localparam int G = 4;
  localparam int S = 16;

  logic         i_clk;
  logic         i_rst_n;
  logic [N-1:0] i_ch_req;
  logic [N-1:0] o_pending;
  logic [N-1:0] o_arb_req;
  logic [N-1:0] o_arb_first_priority;
  logic         o_arb_req_valid;
  logic [N-1:0] i_arb_grant;
  logic         i_arb_grant_valid;
  logic [N-1:0] o_slot_grant;
  logic         o_slot_valid;
  logic [N-1:0] o_slot_done;
  logic         o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int req_wait;

  optical_slot_requester #(
    .P_CHANNEL_NUM(N),
    .P_GUARD_LEN  (G),
    .P_SLOT_LEN   (S),
    .P_WAIT_MAX   (15)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_ch_req            (i_ch_req),
    .o_pending           (o_pending),
    .o_arb_req           (o_arb_req),
    .o_arb_first_priority(o_arb_first_priority),
    .o_arb_req_valid     (o_arb_req_valid),
    .i_arb_grant         (i_arb_grant),
    .i_arb_grant_valid   (i_arb_grant_valid),
    .o_slot_grant        (o_slot_grant),
    .o_slot_valid        (o_slot_valid),
    .o_slot_done         (o_slot_done),
    .o_err               (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed-priority arbiter: first requesting channel at or after the first-priority bit, wrapping.
  function automatic logic [N-1:0] fp_arb(input logic [N-1:0] req, input logic [N-1:0] fp);
    int start = 0;
    int idx;
    logic [N-1:0] g = '0;
    for (int i = 0; i < N; i++) if (fp[i]) start = i;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (req[idx] && (g == '0)) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic wait_req();
    logic found = 1'b0;
    req_wait = 0;
    while (!found && req_wait < 40) begin
      @(negedge i_clk); #1;
      req_wait++;
      if (o_arb_req_valid) found = 1'b1;
    end
    check("req_seen", found, 1);
  endtask

  // Serve one request with the bench arbiter; optionally pulse i_ch_req in the DONE cycle.
  task automatic serve(input logic [N-1:0] exp_g, input logic [N-1:0] collide, input logic [N-1:0] exp_fp);
    logic [N-1:0] g;
    int elapsed = 0;
    int first_v = 0;
    int v_cnt   = 0;
    logic done_seen = 1'b0;
    wait_req();
    g = fp_arb(o_arb_req, o_arb_first_priority);
    check("arb_grant", g, exp_g);
    i_arb_grant = g;
    i_arb_grant_valid = 1'b1;
    #1;
    check("err_good_grant", o_err, 0);
    while (!done_seen && elapsed < 60) begin
      @(negedge i_clk); #1;
      i_arb_grant = '0;
      i_arb_grant_valid = 1'b0;
      elapsed++;
      if (o_slot_valid) begin
        if (v_cnt == 0) first_v = elapsed;
        v_cnt++;
      end
      if (o_slot_done != '0) begin
        done_seen = 1'b1;
        check("slot_done", o_slot_done, exp_g);
        i_ch_req = collide;
      end
    end
    check("req_to_done", elapsed, 1 + G + S);
    check("first_valid", first_v, 1 + G);
    check("valid_len", v_cnt, S);
    @(negedge i_clk);
    i_ch_req = '0;
    #1;
    check("first_prio", o_arb_first_priority, exp_fp);
    check("grant_clear", o_slot_grant, 0);
  endtask

  initial begin
    int el;
    i_rst_n = 1'b0;
    i_ch_req = '0;
    i_arb_grant = '0;
    i_arb_grant_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_pending", o_pending, 0);
    check("rst_arb_req", o_arb_req, 0);
    check("rst_first_prio", o_arb_first_priority, 8'h01);
    check("rst_req_valid", o_arb_req_valid, 0);
    check("rst_slot_grant", o_slot_grant, 0);
    check("rst_slot_valid", o_slot_valid, 0);
    check("rst_slot_done", o_slot_done, 0);
    check("rst_err", o_err, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single request on channel 2
    @(negedge i_clk);
    i_ch_req = 8'h04;
    @(negedge i_clk);
    i_ch_req = '0;
    #1;
    check("t1_pending", o_pending, 8'h04);
    check("t1_no_strobe_yet", o_arb_req_valid, 0);
    @(negedge i_clk); #1;
    check("t1_strobe_cycle2", o_arb_req_valid, 1);
    check("t1_arb_req", o_arb_req, 8'h04);
    check("t1_fp", o_arb_first_priority, 8'h01);
    i_arb_grant = 8'h04;
    i_arb_grant_valid = 1'b1;
    el = 2;
    while (el < 24) begin
      @(negedge i_clk); #1;
      i_arb_grant = '0;
      i_arb_grant_valid = 1'b0;
      el++;
      check("t1_slot_valid", o_slot_valid, (el >= 7 && el <= 22) ? 1 : 0);
      check("t1_slot_done", o_slot_done, (el == 23) ? 8'h04 : 8'h00);
      if (el >= 3 && el <= 22) check("t1_slot_grant", o_slot_grant, 8'h04);
    end
    check("t1_fp_after", o_arb_first_priority, 8'h08);
    check("t1_pending_after", o_pending, 0);

    // Timeout with a late request that must not join the snapshot
    i_ch_req = 8'h10;
    @(negedge i_clk);
    i_ch_req = '0;
    for (int c = 2; c <= 18; c++) begin
      @(negedge i_clk);
      i_ch_req = (c == 5) ? 8'h01 : 8'h00;
      #1;
      check("to_strobe", o_arb_req_valid, (c == 2 || c == 18) ? 1 : 0);
      if (c <= 17) check("to_snapshot_held", o_arb_req, 8'h10);
      if (c == 2) check("to_fp", o_arb_first_priority, 8'h08);
      if (c == 17) check("to_pending", o_pending, 8'h11);
      if (c == 18) begin
        check("to_new_snapshot", o_arb_req, 8'h11);
        i_arb_grant = 8'h00;
        i_arb_grant_valid = 1'b1;
        #1;
        check("zero_grant_no_err", o_err, 0);
      end
    end
    @(negedge i_clk);
    i_arb_grant_valid = 1'b0;
    #1;
    check("zero_grant_no_slot", o_slot_grant, 0);
    check("zero_grant_pending", o_pending, 8'h11);
    serve(8'h10, 8'h00, 8'h20);
    check("to_rerequest_wait", req_wait, 1);
    serve(8'h01, 8'h00, 8'h02);

    // Collision: channel 2 re-requests during its own DONE cycle
    i_ch_req = 8'h04;
    @(negedge i_clk);
    i_ch_req = '0;
    serve(8'h04, 8'h04, 8'h08);
    check("col_pending_kept", o_pending, 8'h04);
    serve(8'h04, 8'h00, 8'h08);
    check("col_new_req_wait", req_wait, 1);
    check("col_pending_clear", o_pending, 0);

    // Bad grant 8'h06 to request 8'h04
    i_ch_req = 8'h04;
    @(negedge i_clk);
    i_ch_req = '0;
    wait_req();
    i_arb_grant = 8'h06;
    i_arb_grant_valid = 1'b1;
    #1;
`ifdef OPTICAL_SLOT_GRANT_CHECK_EN
    check("bad_err_pulse", o_err, 1);
    @(negedge i_clk);
    i_arb_grant = '0;
    i_arb_grant_valid = 1'b0;
    #1;
    check("bad_err_once", o_err, 0);
    check("bad_no_slot", o_slot_grant, 0);
    check("bad_pending", o_pending, 8'h04);
    check("bad_fp", o_arb_first_priority, 8'h08);
    serve(8'h04, 8'h00, 8'h08);
`else
    check("bad_err_off", o_err, 0);
    @(negedge i_clk);
    i_arb_grant = '0;
    i_arb_grant_valid = 1'b0;
    #1;
    check("bad_latched", o_slot_grant, 8'h06);
    el = 0;
    while (o_slot_done == '0 && el < 60) begin
      @(negedge i_clk); #1;
      el++;
    end
    check("bad_slot_done", o_slot_done, 8'h06);
    @(negedge i_clk); #1;
    check("bad_fp_rot", o_arb_first_priority, 8'h0C);
    check("bad_pending_clr", o_pending, 0);
`endif

    // Reset asserted in the middle of a slot
    i_ch_req = 8'h20;
    @(negedge i_clk);
    i_ch_req = '0;
    wait_req();
    i_arb_grant = 8'h20;
    i_arb_grant_valid = 1'b1;
    @(negedge i_clk);
    i_arb_grant = '0;
    i_arb_grant_valid = 1'b0;
    el = 0;
    #1;
    while (!o_slot_valid && el < 20) begin
      @(negedge i_clk); #1;
      el++;
    end
    check("mr_in_slot", o_slot_valid, 1);
    repeat (3) @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("mr_slot_valid", o_slot_valid, 0);
    check("mr_slot_grant", o_slot_grant, 0);
    check("mr_slot_done", o_slot_done, 0);
    check("mr_pending", o_pending, 0);
    check("mr_arb_req", o_arb_req, 0);
    check("mr_fp", o_arb_first_priority, 8'h01);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk); #1;
      check("mr_no_done", o_slot_done, 0);
      check("mr_no_valid", o_slot_valid, 0);
    end

    // Round-robin over all eight channels
    i_ch_req = 8'hFF;
    @(negedge i_clk);
    i_ch_req = '0;
    for (int i = 0; i < N; i++) begin
      logic [N-1:0] eg;
      logic [N-1:0] ef;
      eg = '0;
      ef = '0;
      eg[i] = 1'b1;
      ef[(i + 1) % N] = 1'b1;
      serve(eg, 8'h00, ef);
    end
    check("rr_fp_wrap", o_arb_first_priority, 8'h01);
    check("rr_pending_empty", o_pending, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/optical_slot_requester.md
# optical_slot_requester

Requester-side companion to the fixed-priority grant arbiter in the optical 8x8 controller. Collects per-channel connection requests into a pending set and drives the arbiter's request vector, one-hot first-priority and request-valid strobe. Samples the returned grant, then runs a guard interval for optical switch reconfiguration followed by a fixed-length transmit slot for the granted channel. Rotates priority past the served channel for round-robin fairness.

## Interface
- P_CHANNEL_NUM, 8, number of channels (request/grant vector width)
- P_GUARD_LEN, 4, guard cycles before slot (>=1)
- P_SLOT_LEN, 16, slot cycles with o_slot_valid high (>=1)
- P_WAIT_MAX, 15, max cycles waited for grant after request strobe (>=1)

- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_ch_req  in  P_CHANNEL_NUM  per-channel request pulse; sets pending bit
- o_pending  out  P_CHANNEL_NUM  pending request set
- o_arb_req  out  P_CHANNEL_NUM  request snapshot to arbiter
- o_arb_first_priority  out  P_CHANNEL_NUM  one-hot highest-priority channel
- o_arb_req_valid  out  1  one-cycle request strobe
- i_arb_grant  in  P_CHANNEL_NUM  grant from arbiter
- i_arb_grant_valid  in  1  grant qualifier
- o_slot_grant  out  P_CHANNEL_NUM  one-hot granted channel, held GUARD through SLOT
- o_slot_valid  out  1  high during slot cycles only
- o_slot_done  out  P_CHANNEL_NUM  one-cycle pulse on served channel at slot end
- o_err  out  1  one-cycle pulse on bad grant (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, GUARD, SLOT, DONE.
- Pending: bit set on i_ch_req. Bit cleared in DONE for the served channel. A new i_ch_req on that bit in the same cycle wins (bit stays set).
- IDLE: if o_pending != 0, go to REQ and latch o_arb_req <= o_pending.
- REQ: o_arb_req_valid = 1 for exactly one cycle. Grant is sampled in this cycle too, since the arbiter answers combinationally.
- WAIT: wait counter counts cycles.
  - Grant sampling rule (REQ and WAIT): i_arb_grant_valid=1 with nonzero grant -> latch o_slot_grant, go to GUARD.
  - i_arb_grant_valid=1 with zero grant -> IDLE.
  - Counter reaching P_WAIT_MAX -> IDLE. Pending is unchanged, so the block re-requests.
- GUARD: P_GUARD_LEN cycles, o_slot_valid=0, o_slot_grant driven.
- SLOT: P_SLOT_LEN cycles, o_slot_valid=1.
- DONE: one cycle.
  - o_slot_done = o_slot_grant.
  - Clear pending bit.
  - o_arb_first_priority <= o_slot_grant rotated left by 1 (bit N-1 wraps to bit 0).
  - o_slot_grant <= 0. Next state IDLE.
- o_arb_req is held constant from REQ through WAIT. Requests arriving after the snapshot go only to pending.
- Counters are sized $clog2(max param)+1. Each counter clears on state entry.

## Timing
- Reset (async assert, sync-released in effect):
  - o_arb_first_priority = 1 (bit 0). State IDLE.
  - All other outputs and pending = 0. Counters = 0.
- i_ch_req in cycle 0: pending visible cycle 1, REQ (o_arb_req_valid) cycle 2.
- Grant in cycle 2:
  - GUARD cycles 3..2+G.
  - o_slot_valid cycles 3+G..2+G+S.
  - o_slot_done cycle 3+G+S.
  - IDLE cycle 4+G+S.
  - Earliest next REQ cycle 5+G+S.
- Grant arriving in the DONE/GUARD/SLOT/IDLE states is ignored.
- Reset mid-slot: outputs drop immediately, no o_slot_done.

## Configuration
- OPTICAL_SLOT_GRANT_CHECK_EN defined:
  - Applies only when the sampled grant is nonzero. A zero grant always returns to IDLE per the grant sampling rule, with no o_err.
  - A nonzero grant that is not one-hot, or has any bit outside o_arb_req, produces one o_err pulse in the sampling cycle and returns to IDLE. Pending and priority are unchanged.
- Undefined:
  - Nonzero grant is latched as-is (assumed one-hot).
  - o_err is tied 0.

## Test plan
- Single request: i_ch_req=8'h04 in cycle 0; bench arbiter grants 8'h04 in cycle 2. Required:
  - o_arb_req=8'h04 with first_priority=8'h01.
  - o_slot_valid high 16 cycles starting cycle 7.
  - o_slot_done=8'h04 in cycle 23.
  - first_priority becomes 8'h08.
  - o_pending=0.
- Round-robin: pending 8'hFF with a real fixed-priority arbiter. Grants must follow the order 0,1,...,7, with first_priority wrapping 8'h80 -> 8'h01.
- Timeout: no grant_valid after the request. Required: return to IDLE 15 cycles after the strobe, then a fresh o_arb_req_valid with pending unchanged.
- Collision: i_ch_req bit 2 in the DONE cycle of channel 2. o_pending[2] stays 1 and a new request is issued.
- Bad grant (macro on): grant 8'h06 to request 8'h04 -> o_err pulse, no slot. Macro off -> slot runs with o_slot_grant=8'h06.
- Reset asserted mid-SLOT: all outputs 0 immediately, first_priority=8'h01, no o_slot_done pulse.
